// File: rtl/lsb_pkg.sv
// Shared constants and types for the load/store buffer.
package lsb_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W = 3;

  // Load funct3 encodings
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [F3_W-1:0] F3_SB  = 3'b000;
  localparam logic [F3_W-1:0] F3_SH  = 3'b001;
  localparam logic [F3_W-1:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } lsb_state_e;

  // Byte-lane replication used for sign extension
  function automatic logic [XLEN-1:0] sext8(input logic [7:0] b);
    sext8 = {{(XLEN-8){b[7]}}, b};
  endfunction

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] h);
    sext16 = {{(XLEN-16){h[15]}}, h};
  endfunction

endpackage

// File: rtl/lsb_load_align.sv
// Extends an LSB-aligned raw memory word according to the load funct3.
module lsb_load_align
  import lsb_pkg::*;
(
  input  logic [F3_W-1:0] width,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] aligned_c
);

  // Sign or zero extension selected by load width
  always_comb begin
    aligned_c = raw;
    case (width)
      F3_LB:   aligned_c = sext8(raw[7:0]);
      F3_LH:   aligned_c = sext16(raw[15:0]);
      F3_LBU:  aligned_c = {24'h000000, raw[7:0]};
      F3_LHU:  aligned_c = {16'h0000, raw[15:0]};
      default: aligned_c = raw;
    endcase
  end

endmodule

// File: rtl/lsb_queue.sv
// In-order load/store buffer: operand wakeup from CDB, commit-gated stores,
// speculative loads, single outstanding memory request, flush recovery.
module lsb_queue
  import lsb_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned ROB_W = 4,
  parameter  int unsigned CDB_N = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic                   disp_is_store,
  input  logic [F3_W-1:0]        disp_width,
  input  logic [ROB_W-1:0]       disp_rob,
  input  logic [XLEN-1:0]        disp_base_val,
  input  logic [XLEN-1:0]        disp_data_val,
  input  logic [XLEN-1:0]        disp_imm,
  input  logic                   disp_base_wait,
  input  logic                   disp_data_wait,
  input  logic [ROB_W-1:0]       disp_base_tag,
  input  logic [ROB_W-1:0]       disp_data_tag,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*ROB_W-1:0] cdb_tag,
  input  logic [CDB_N*XLEN-1:0]  cdb_value,
  input  logic                   commit_valid,
  input  logic [ROB_W-1:0]       commit_rob,
  output logic                   mem_req_valid,
  output logic                   mem_req_write,
  output logic [XLEN-1:0]        mem_req_addr,
  output logic [XLEN-1:0]        mem_req_data,
  output logic [F3_W-1:0]        mem_req_width,
  input  logic                   mem_resp_valid,
  input  logic [XLEN-1:0]        mem_resp_data,
  output logic                   ld_valid,
  output logic [ROB_W-1:0]       ld_rob,
  output logic [XLEN-1:0]        ld_value,
  output logic [CNT_W-1:0]       count,
  output logic                   full,
  output logic                   empty
);

  // Entry storage
  logic [DEPTH-1:0] valid, is_store, committed, base_wait, data_wait;
  logic [F3_W-1:0]  width_q  [DEPTH];
  logic [ROB_W-1:0] rob_q    [DEPTH];
  logic [ROB_W-1:0] base_tag [DEPTH];
  logic [ROB_W-1:0] data_tag [DEPTH];
  logic [XLEN-1:0]  base_val [DEPTH];
  logic [XLEN-1:0]  data_val [DEPTH];
  logic [XLEN-1:0]  imm_q    [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] ccount;
  lsb_state_e       state;

  // Next-state helpers
  logic [DEPTH-1:0] base_hit, data_hit;
  logic [XLEN-1:0]  base_cdb [DEPTH];
  logic [XLEN-1:0]  data_cdb [DEPTH];
  logic             disp_base_hit, disp_data_hit;
  logic [XLEN-1:0]  disp_base_cdb, disp_data_cdb;
  logic             commit_hit;
  logic [PTR_W-1:0] commit_idx;
  logic             pop, head_flushed, adv, push, head_ready;
  logic [PTR_W-1:0] head_nxt, tail_nxt;
  logic [CNT_W-1:0] count_nxt, ccount_nxt;
  logic [XLEN-1:0]  aligned;

  // Returns {hit, value} for the highest-numbered CDB channel matching tag
  function automatic logic [XLEN:0] cdb_match(
    input logic [ROB_W-1:0]       tag,
    input logic [CDB_N-1:0]       cv,
    input logic [CDB_N*ROB_W-1:0] ct,
    input logic [CDB_N*XLEN-1:0]  cval
  );
    cdb_match = '0;
    for (int c = 0; c < CDB_N; c++) begin
      if (cv[c] && (ct[c*ROB_W +: ROB_W] == tag)) begin
        cdb_match = {1'b1, cval[c*XLEN +: XLEN]};
      end
    end
  endfunction

  lsb_load_align u_align (
    .width     (mem_req_width),
    .raw       (mem_resp_data),
    .aligned_c (aligned)
  );

  // CDB tag comparison for stored entries and the dispatching op
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {base_hit[i], base_cdb[i]} = cdb_match(base_tag[i], cdb_valid, cdb_tag, cdb_value);
      {data_hit[i], data_cdb[i]} = cdb_match(data_tag[i], cdb_valid, cdb_tag, cdb_value);
    end
    {disp_base_hit, disp_base_cdb} = cdb_match(disp_base_tag, cdb_valid, cdb_tag, cdb_value);
    {disp_data_hit, disp_data_cdb} = cdb_match(disp_data_tag, cdb_valid, cdb_tag, cdb_value);
  end

  // Commit lookup, pointer and occupancy arithmetic, head readiness
  always_comb begin
    commit_hit = 1'b0;
    commit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid && valid[i] && is_store[i] && !committed[i] &&
          (rob_q[i] == commit_rob)) begin
        commit_hit = 1'b1;
        commit_idx = PTR_W'(i);
      end
    end

    pop          = (state == S_WAIT) && mem_resp_valid;
    // An in-flight load at flush leaves the queue now; its response is drained
    head_flushed = flush && (state == S_WAIT) && !is_store[head];
    adv          = pop || head_flushed;
    push         = disp_valid && !full && !flush;

    head_nxt   = head + PTR_W'(adv);
    ccount_nxt = ccount + CNT_W'(commit_hit) - CNT_W'(pop && is_store[head]);

    if (flush) begin
      tail_nxt  = head_nxt + PTR_W'(ccount_nxt);
      count_nxt = ccount_nxt;
    end else begin
      tail_nxt  = tail + PTR_W'(push);
      count_nxt = count + CNT_W'(push) - CNT_W'(adv);
    end

    head_ready = valid[head] && !base_wait[head] &&
                 (!is_store[head] || (!data_wait[head] && committed[head]));
  end

  // Queue storage, pointers, wakeup, commit marking and flush recovery
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ccount     <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
      disp_ready <= 1'b1;
      valid      <= '0;
      is_store   <= '0;
      committed  <= '0;
      base_wait  <= '0;
      data_wait  <= '0;
    end else if (rdy) begin
      head       <= head_nxt;
      tail       <= tail_nxt;
      count      <= count_nxt;
      ccount     <= ccount_nxt;
      full       <= (count_nxt == CNT_W'(DEPTH));
      empty      <= (count_nxt == '0);
      disp_ready <= (count_nxt != CNT_W'(DEPTH));

      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && base_wait[i] && base_hit[i]) begin
          base_val[i]  <= base_cdb[i];
          base_wait[i] <= 1'b0;
        end
        if (valid[i] && data_wait[i] && data_hit[i]) begin
          data_val[i]  <= data_cdb[i];
          data_wait[i] <= 1'b0;
        end
        // Same-cycle commit counts as committed for the flush
        if (flush && !committed[i] && !(commit_hit && (commit_idx == PTR_W'(i)))) begin
          valid[i] <= 1'b0;
        end
      end

      if (commit_hit) begin
        committed[commit_idx] <= 1'b1;
      end

      if (adv) begin
        valid[head]     <= 1'b0;
        committed[head] <= 1'b0;
      end

      if (push) begin
        valid[tail]     <= 1'b1;
        is_store[tail]  <= disp_is_store;
        committed[tail] <= 1'b0;
        width_q[tail]   <= disp_width;
        rob_q[tail]     <= disp_rob;
        imm_q[tail]     <= disp_imm;
        base_tag[tail]  <= disp_base_tag;
        data_tag[tail]  <= disp_data_tag;
        base_val[tail]  <= (disp_base_wait && disp_base_hit) ? disp_base_cdb : disp_base_val;
        base_wait[tail] <= disp_base_wait && !disp_base_hit;
        data_val[tail]  <= (disp_data_wait && disp_data_hit) ? disp_data_cdb : disp_data_val;
        data_wait[tail] <= disp_is_store && disp_data_wait && !disp_data_hit;
      end
    end
  end

  // Head issue FSM with registered memory request and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      mem_req_width <= '0;
      ld_valid      <= 1'b0;
      ld_rob        <= '0;
      ld_value      <= '0;
    end else if (rdy) begin
      ld_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!flush && head_ready) begin
            state         <= S_WAIT;
            mem_req_valid <= 1'b1;
            mem_req_write <= is_store[head];
            mem_req_addr  <= base_val[head] + imm_q[head];
            mem_req_data  <= is_store[head] ? data_val[head] : '0;
            mem_req_width <= width_q[head];
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            state         <= S_IDLE;
            mem_req_valid <= 1'b0;
            if (!is_store[head] && !flush) begin
              ld_valid <= 1'b1;
              ld_rob   <= rob_q[head];
              ld_value <= aligned;
            end
          end else if (flush && !is_store[head]) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_resp_valid) begin
            state         <= S_IDLE;
            mem_req_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue.
module tb_lsb_queue;
  import lsb_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        disp_valid, disp_ready, disp_is_store;
  logic [2:0]  disp_width;
  logic [3:0]  disp_rob;
  logic [31:0] disp_base_val, disp_data_val, disp_imm;
  logic        disp_base_wait, disp_data_wait;
  logic [3:0]  disp_base_tag, disp_data_tag;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        commit_valid;
  logic [3:0]  commit_rob;
  logic        mem_req_valid, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_data;
  logic [2:0]  mem_req_width;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        ld_valid;
  logic [3:0]  ld_rob;
  logic [31:0] ld_value;
  logic [4:0]  count;
  logic        full, empty;

  int errors = 0;
  int checks = 0;

  lsb_queue #(.DEPTH(16), .ROB_W(4), .CDB_N(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_store(disp_is_store),
    .disp_width(disp_width), .disp_rob(disp_rob),
    .disp_base_val(disp_base_val), .disp_data_val(disp_data_val), .disp_imm(disp_imm),
    .disp_base_wait(disp_base_wait), .disp_data_wait(disp_data_wait),
    .disp_base_tag(disp_base_tag), .disp_data_tag(disp_data_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_rob(commit_rob),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_width(mem_req_width),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .ld_valid(ld_valid), .ld_rob(ld_rob), .ld_value(ld_value),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic disp(input logic st, input logic [2:0] w, input logic [3:0] rob,
                      input logic [31:0] base, input logic bw, input logic [3:0] bt,
                      input logic [31:0] data, input logic dw, input logic [3:0] dt,
                      input logic [31:0] imm);
    disp_valid = 1'b1; disp_is_store = st; disp_width = w; disp_rob = rob;
    disp_base_val = base; disp_base_wait = bw; disp_base_tag = bt;
    disp_data_val = data; disp_data_wait = dw; disp_data_tag = dt; disp_imm = imm;
    tick();
    disp_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] raw);
    mem_resp_valid = 1'b1; mem_resp_data = raw;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic commit(input logic [3:0] rob);
    commit_valid = 1'b1; commit_rob = rob;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic wait_req(input int max);
    int n = 0;
    while (mem_req_valid !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    check("wait_req", 32'(mem_req_valid), 32'h1);
  endtask

  task automatic do_load(input logic [2:0] w, input logic [3:0] rob,
                         input logic [31:0] raw, input logic [31:0] exp, input string tag);
    disp(1'b0, w, rob, 32'h10, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    tick();
    check({tag, "_req"}, 32'(mem_req_valid), 32'h1);
    resp(raw);
    check({tag, "_ldv"}, 32'(ld_valid), 32'h1);
    check({tag, "_val"}, ld_value, exp);
    tick();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    disp_valid = 1'b0; disp_is_store = 1'b0; disp_width = '0; disp_rob = '0;
    disp_base_val = '0; disp_data_val = '0; disp_imm = '0;
    disp_base_wait = 1'b0; disp_data_wait = 1'b0; disp_base_tag = '0; disp_data_tag = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    commit_valid = 1'b0; commit_rob = '0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset state
    tick(); tick();
    check("rst_count", 32'(count), 32'h0);
    check("rst_empty", 32'(empty), 32'h1);
    check("rst_full", 32'(full), 32'h0);
    check("rst_ready", 32'(disp_ready), 32'h1);
    check("rst_req", 32'(mem_req_valid), 32'h0);
    check("rst_ldv", 32'(ld_valid), 32'h0);
    check("rst_addr", mem_req_addr, 32'h0);
    rst = 1'b0;
    tick();

    // LW with resolved base: count next cycle, request one cycle later
    disp(1'b0, F3_LW, 4'd1, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h4);
    check("lw_count", 32'(count), 32'h1);
    check("lw_req_early", 32'(mem_req_valid), 32'h0);
    tick();
    check("lw_req", 32'(mem_req_valid), 32'h1);
    check("lw_addr", mem_req_addr, 32'h104);
    check("lw_write", 32'(mem_req_write), 32'h0);
    check("lw_width", 32'(mem_req_width), 32'h2);
    tick();
    check("lw_hold", mem_req_addr, 32'h104);
    resp(32'hDEADBEEF);
    check("lw_ldv", 32'(ld_valid), 32'h1);
    check("lw_rob", 32'(ld_rob), 32'h1);
    check("lw_val", ld_value, 32'hDEADBEEF);
    check("lw_req_drop", 32'(mem_req_valid), 32'h0);
    check("lw_empty", 32'(empty), 32'h1);
    tick();
    check("lw_pulse", 32'(ld_valid), 32'h0);

    // Load extension patterns
    do_load(F3_LB,  4'd2, 32'h00000080, 32'hFFFFFF80, "lb");
    do_load(F3_LBU, 4'd3, 32'hABCD0080, 32'h00000080, "lbu");
    do_load(F3_LH,  4'd4, 32'h00008001, 32'hFFFF8001, "lh");
    do_load(F3_LHU, 4'd5, 32'h12348001, 32'h00008001, "lhu");
    do_load(F3_LB,  4'd6, 32'hFFFFFF7F, 32'h0000007F, "lb_pos");

    // Store waiting on data tag 3, woken by CDB ch1, held until commit
    disp(1'b1, F3_SW, 4'd5, 32'h200, 1'b0, 4'h0, 32'h0, 1'b1, 4'd3, 32'h0);
    tick();
    check("st_nocommit", 32'(mem_req_valid), 32'h0);
    cdb_valid = 2'b10; cdb_tag = 8'h30; cdb_value = {32'h55, 32'h0};
    tick();
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    tick();
    check("st_woken_nocommit", 32'(mem_req_valid), 32'h0);
    commit(4'd7);
    tick();
    check("st_wrong_commit", 32'(mem_req_valid), 32'h0);
    commit(4'd5);
    check("st_commit_edge", 32'(mem_req_valid), 32'h0);
    tick();
    check("st_req", 32'(mem_req_valid), 32'h1);
    check("st_write", 32'(mem_req_write), 32'h1);
    check("st_data", mem_req_data, 32'h55);
    check("st_addr", mem_req_addr, 32'h200);
    resp(32'h0);
    check("st_ldv", 32'(ld_valid), 32'h0);
    check("st_empty", 32'(empty), 32'h1);
    tick();

    // Fill to DEPTH with loads waiting on tag 9
    for (int k = 0; k < 16; k++) begin
      disp(1'b0, F3_LW, 4'(k), 32'h0, 1'b1, 4'd9, 32'h0, 1'b0, 4'h0, 32'(k * 4));
    end
    check("full_count", 32'(count), 32'd16);
    check("full_flag", 32'(full), 32'h1);
    check("full_ready", 32'(disp_ready), 32'h0);
    disp(1'b1, F3_SW, 4'd15, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    check("full_ignored", 32'(count), 32'd16);
    check("full_noreq", 32'(mem_req_valid), 32'h0);
    cdb_valid = 2'b01; cdb_tag = 8'h09; cdb_value = {32'h0, 32'h300};
    tick();
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    wait_req(4);
    check("full_addr", mem_req_addr, 32'h300);
    resp(32'h1234);
    check("pop_count", 32'(count), 32'd15);
    check("pop_full", 32'(full), 32'h0);
    check("pop_ready", 32'(disp_ready), 32'h1);
    check("pop_ldv", 32'(ld_valid), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_all_count", 32'(count), 32'h0);
    check("flush_all_empty", 32'(empty), 32'h1);
    check("flush_all_req", 32'(mem_req_valid), 32'h0);
    tick();

    // Flush with in-flight load; two committed stores survive
    disp(1'b0, F3_LW, 4'd1, 32'h400, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
    disp(1'b1, F3_SW, 4'd2, 32'h500, 1'b0, 4'h0, 32'hA1, 1'b0, 4'h0, 32'h0);
    check("fl_l1_req", mem_req_addr, 32'h400);
    disp(1'b1, F3_SW, 4'd3, 32'h504, 1'b0, 4'h0, 32'hA2, 1'b0, 4'h0, 32'h0);
    disp(1'b0, F3_LW, 4'd4, 32'h0, 1'b1, 4'd12, 32'h0, 1'b0, 4'h0, 32'h0);
    disp(1'b0, F3_LW, 4'd5, 32'h0, 1'b1, 4'd12, 32'h0, 1'b0, 4'h0, 32'h0);
    check("fl_count5", 32'(count), 32'd5);
    commit(4'd2);
    commit(4'd3);
    check("fl_inflight", 32'(mem_req_valid), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_count2", 32'(count), 32'd2);
    check("fl_drain_req", 32'(mem_req_valid), 32'h1);
    resp(32'h99);
    check("fl_drain_ldv", 32'(ld_valid), 32'h0);
    check("fl_drain_drop", 32'(mem_req_valid), 32'h0);
    tick();
    check("fl_s1_req", 32'(mem_req_valid), 32'h1);
    check("fl_s1_addr", mem_req_addr, 32'h500);
    check("fl_s1_data", mem_req_data, 32'hA1);
    check("fl_s1_write", 32'(mem_req_write), 32'h1);
    resp(32'h0);
    check("fl_count1", 32'(count), 32'd1);
    tick();
    check("fl_s2_addr", mem_req_addr, 32'h504);
    check("fl_s2_data", mem_req_data, 32'hA2);
    resp(32'h0);
    check("fl_empty", 32'(empty), 32'h1);
    check("fl_s2_ldv", 32'(ld_valid), 32'h0);
    tick();

    // Dispatch bypass from CDB; rdy low freezes an outstanding request
    cdb_valid = 2'b11; cdb_tag = 8'hBA; cdb_value = {32'h77, 32'h600};
    disp(1'b0, F3_LW, 4'd6, 32'h0, 1'b1, 4'd10, 32'h0, 1'b0, 4'h0, 32'h8);
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    check("byp_ld_early", 32'(mem_req_valid), 32'h0);
    tick();
    check("byp_ld_req", 32'(mem_req_valid), 32'h1);
    check("byp_ld_addr", mem_req_addr, 32'h608);
    rdy = 1'b0;
    tick(); tick();
    check("rdy_hold_req", 32'(mem_req_valid), 32'h1);
    check("rdy_hold_count", 32'(count), 32'h1);
    rdy = 1'b1;
    resp(32'h5);
    check("byp_ld_val", ld_value, 32'h5);
    tick();
    cdb_valid = 2'b11; cdb_tag = 8'hBA; cdb_value = {32'h77, 32'h600};
    disp(1'b1, F3_SW, 4'd7, 32'h0, 1'b1, 4'd10, 32'h0, 1'b1, 4'd11, 32'h0);
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
    commit(4'd7);
    tick();
    check("byp_st_req", 32'(mem_req_valid), 32'h1);
    check("byp_st_addr", mem_req_addr, 32'h600);
    check("byp_st_data", mem_req_data, 32'h77);
    resp(32'h0);
    check("byp_st_empty", 32'(empty), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
